// File: rtl/present_round_ctrl.sv
// Iterative PRESENT-80 encryption controller: one round per clock with the 80-bit key schedule alongside.
// Optional abort input is enabled with `define PRESENT_ABORT_EN.
module present_round_ctrl #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef PRESENT_ABORT_EN
    input  logic        abort,
`endif
    input  logic [63:0] din,
    input  logic [79:0] key,
    output logic        busy,
    output logic        done,
    output logic [63:0] dout
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic [63:0] st_q, st_d;
    logic [79:0] k_q, k_d;
    logic [5:0]  rc_q, rc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] dout_q, dout_d;

    logic        abort_w;
    logic [63:0] round_out;
    logic [79:0] k_rot, k_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y     = '0;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
        return y;
    endfunction

`ifdef PRESENT_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Datapath: round function on the state and next key in the schedule.
    always_comb begin
        round_out        = p_layer(s_layer(st_q ^ k_q[79:16]));
        k_rot            = {k_q[18:0], k_q[79:19]};
        k_next           = k_rot;
        k_next[79:76]    = sbox(k_rot[79:76]);
        k_next[19:15]    = k_rot[19:15] ^ rc_q[4:0];
    end

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        k_d    = k_q;
        rc_d   = rc_q;
        busy_d = busy_q;
        done_d = 1'b0;
        dout_d = dout_q;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    st_d   = din;
                    k_d    = key;
                    rc_d   = 6'd1;
                    busy_d = 1'b1;
                    fsm_d  = RUN;
                end
            end
            RUN: begin
                if (abort_w) begin
                    busy_d = 1'b0;
                    rc_d   = '0;
                    fsm_d  = IDLE;
                end else begin
                    st_d = round_out;
                    k_d  = k_next;
                    rc_d = rc_q + 6'd1;
                    if (rc_q == 6'(ROUNDS)) fsm_d = FIN;
                end
            end
            FIN: begin
                if (abort_w) begin
                    busy_d = 1'b0;
                    rc_d   = '0;
                    fsm_d  = IDLE;
                end else begin
                    // Final key whitening with the key left by the last round.
                    dout_d = st_q ^ k_q[79:16];
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            k_q    <= '0;
            rc_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dout_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            k_q    <= k_d;
            rc_q   <= rc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dout_q <= dout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Scoreboard bench for present_round_ctrl: an algorithmic PRESENT model feeds expected
// ciphertexts into a queue that a negedge monitor drains on every done pulse.
module tb_present_round_ctrl;
    localparam int ROUNDS = 31;
    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] din = '0;
    logic [79:0] key = '0;
    logic        busy, done;
    logic [63:0] dout;
`ifdef PRESENT_ABORT_EN
    logic        abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    present_round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
`ifdef PRESENT_ABORT_EN
        .abort(abort),
`endif
        .din  (din),
        .key  (key),
        .busy (busy),
        .done (done),
        .dout (dout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Straight-line PRESENT-80 from the algorithm description.
    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k0);
        logic [63:0] s, t;
        logic [79:0] k;
        s = pt;
        k = k0;
        for (int r = 1; r <= ROUNDS; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
            s = t;
            k = (k << 61) | (k >> 19);
            k[79:76] = SB[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // Transaction-level model: which edge accepts a block, when busy ends, when done fires.
    logic [63:0] exp_q[$];
    int edge_n    = 0;
    int acc_edge  = -100;
    int busy_end  = -1;
    int done_edge = -1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            acc_edge  <= -100;
            busy_end  <= -1;
            done_edge <= -1;
        end else begin
            edge_n <= edge_n + 1;
            if (start && (edge_n + 1 > busy_end)) begin
                acc_edge  <= edge_n + 1;
                busy_end  <= edge_n + 1 + ROUNDS + 1;
                done_edge <= edge_n + 1 + ROUNDS + 1;
                exp_q.push_back(ref_enc(din, key));
            end
`ifdef PRESENT_ABORT_EN
            else if (abort && (edge_n + 1 > acc_edge) && (edge_n + 1 <= busy_end)) begin
                busy_end  <= edge_n + 1;
                done_edge <= -1;
                void'(exp_q.pop_back());
            end
`endif
        end
    end

    logic [63:0] hold_exp = '0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            hold_exp <= '0;
        end else begin
            chk("mon_busy", 64'(busy), 64'(edge_n < busy_end));
            chk("mon_done", 64'(done), 64'(edge_n == done_edge));
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_done: dout %h with empty queue", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_dout", dout, e);
                    hold_exp <= e;
                end
            end else begin
                chk("mon_dout_hold", dout, hold_exp);
            end
        end
    end

    task automatic issue(input logic [63:0] d, input logic [79:0] k);
        @(negedge clk);
        start = 1'b1;
        din   = d;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge; waits a bounded time for done.
    task automatic wait_done(input string name, input logic [63:0] exp, input bit noise);
        int  nb;
        bit  got;
        nb  = 0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (busy) nb++;
            if (done) begin
                got = 1'b1;
                chk({name, "_dout"}, dout, exp);
                chk({name, "_latency"}, 64'(c), 64'(ROUNDS + 1));
                chk({name, "_busy_cycles"}, 64'(nb), 64'(ROUNDS + 1));
            end else begin
                @(negedge clk);
                din = {$urandom, $urandom};
                key = {$urandom, $urandom, $urandom};
                if (noise) start = (c < 25) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 60 cycles", name);
        end
    endtask

    initial begin
        logic [63:0] d, e;
        logic [79:0] k;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dout", dout, 64'd0);

        issue(64'h0, 80'h0);
        wait_done("vec_zero", 64'h5579C1387B228445, 1'b0);
        issue(64'h0, {80{1'b1}});
        wait_done("vec_key_ones", 64'hE72C46C0F5945049, 1'b0);
        issue({64{1'b1}}, 80'h0);
        wait_done("vec_pt_ones", 64'hA112FFC72F68417B, 1'b0);
        issue({64{1'b1}}, {80{1'b1}});
        wait_done("vec_all_ones", 64'h3333DCD3213210D2, 1'b0);

        // Start held high: the second block is taken in the IDLE cycle right after done.
        @(negedge clk);
        start = 1'b1;
        din   = 64'h0;
        key   = {80{1'b1}};
        @(negedge clk);
        wait_done("b2b_first", 64'hE72C46C0F5945049, 1'b0);
        din = {64{1'b1}};
        key = 80'h0;
        @(negedge clk);
        wait_done("b2b_second", 64'hA112FFC72F68417B, 1'b0);
        start = 1'b0;

        // Asynchronous reset in the middle of a block.
        issue(64'h0123456789ABCDEF, 80'h00112233445566778899);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_dout", dout, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(64'h0, 80'h0);
        wait_done("after_rst", 64'h5579C1387B228445, 1'b0);

        for (int i = 0; i < 12; i++) begin
            d = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom};
            e = ref_enc(d, k);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(d, k);
            wait_done("rand", e, 1'b1);
            start = 1'b0;
        end

`ifdef PRESENT_ABORT_EN
        issue(64'h0, {80{1'b1}});
        wait_done("pre_abort", 64'hE72C46C0F5945049, 1'b0);
        issue(64'hDEADBEEFCAFEF00D, 80'h13579BDF02468ACE1357);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_dout_kept", dout, 64'hE72C46C0F5945049);
        repeat (40) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        din   = {64{1'b1}};
        key   = 80'h0;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        wait_done("abort_start_same", 64'hA112FFC72F68417B, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
